// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor.
// Processes DIGIT bits per clock over WIDTH/DIGIT cycles, keeping the carry in
// a register between digits. Subtraction is A + ~B + ~borrow_in. Valid/ready
// handshakes on both the operand and result sides; one operation in flight.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  // Reject parameter sets that cannot be split into whole digits.
  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_r;      // operand A as accepted
  logic [WIDTH-1:0] b_r;      // operand B, already inverted for subtract
  logic            cy_r;      // carry between digits
  logic [CW-1:0]   cnt;       // index of the digit being processed

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;  // carry into the top bit of this digit
  logic [WIDTH-1:0] next_result;
  logic             c;

  // Ripple-add the current digit and merge it into the partial result.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves a value unassigned and no latch is inferred.
    dig_a       = a_r[cnt*DIGIT +: DIGIT];
    dig_b       = b_r[cnt*DIGIT +: DIGIT];
    dig_sum     = '0;
    dig_cmsb    = cy_r;
    c           = cy_r;
    for (int i = 0; i < DIGIT; i++) begin
      dig_cmsb   = c;
      dig_sum[i] = dig_a[i] ^ dig_b[i] ^ c;
      c          = (dig_a[i] & dig_b[i]) | (c & (dig_a[i] ^ dig_b[i]));
    end
    dig_cout    = c;
    next_result = result;
    next_result[cnt*DIGIT +: DIGIT] = dig_sum;
  end

  // Control FSM with registered handshake outputs, datapath and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, datapath included, is reset so that the flags and
    // result never show X after reset release and an abandoned operation
    // leaves nothing behind.
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      cy_r      <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the values from before this edge regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b ^ {WIDTH{mode}};
            cy_r     <= mode ? ~cin : cin;
            result   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result <= next_result;
          cy_r   <= dig_cout;
          if (cnt == LAST) begin
            cnt       <= '0;
            carry     <= dig_cout;
            overflow  <= dig_cout ^ dig_cmsb;
            zero      <= (next_result == '0);
            negative  <= next_result[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
